mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single external memory port (mem_address/op, common data bus) among three requesters:
//  host write-in (WR), audio/FFT data read (AU) and instruction fetch (IF). Runs one transaction at a time,
//  holds address/op stable until memory responds, returns the 512b read line and flags hung transactions.
//  Sits between the CPU pipeline/Fetch and the DMA/memory interface.
// PARAMETERS
//  ADDRW        32    address width
//  INW          512   data bus / cache-line width
//  TIMEOUT_CYC  1024  max cycles in BUSY before abort (>=2)
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous, active-high reset
//  wr_req       in   1      host write request; held with wr_addr until wr_done/timeout
//  wr_addr      in   ADDRW  write address
//  wr_gnt       out  1      WR owns port (ISSUE+BUSY)
//  wr_done      out  1      1-cycle pulse: write completed
//  au_req       in   1      audio read request
//  au_addr      in   ADDRW  audio read address
//  au_gnt       out  1      AU owns port
//  au_valid     out  1      1-cycle pulse: rsp_data valid for AU
//  if_req       in   1      fetch read request
//  if_addr      in   ADDRW  fetch address
//  if_gnt       out  1      IF owns port
//  if_valid     out  1      1-cycle pulse: rsp_data valid for IF
//  rsp_data     out  INW    registered read line
//  mem_op       out  2      00 idle, 01 read, 10 write
//  mem_address  out  ADDRW  memory address
//  rd_valid     in   1      memory read data valid on common_data_bus_in
//  tx_done      in   1      memory write complete
//  common_data_bus_in in INW read data
//  timeout_err  out  1      1-cycle pulse: transaction aborted
//  err_id       out  2      owner of aborted transaction (valid with timeout_err)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (mem_op=00, rsp_data=0, counters 0). Reset mid-transaction: next cycle IDLE,
//   outputs 0, owner cleared; a late rd_valid/tx_done is ignored.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: if any req, register winner as owner, latch its address; next cycle BUSY. No req: stay.
//  BUSY: mem_op = 01 (AU/IF) or 10 (WR), mem_address = latched addr, owner gnt=1, timer counts from 0.
//   Read owner + rd_valid: latch common_data_bus_in to rsp_data -> RESP. Write owner + tx_done -> RESP.
//   Wrong-type response (tx_done on read, rd_valid on write) ignored.
//   timer == TIMEOUT_CYC-1 with no response -> RESP with abort flag; response in that same cycle wins over abort.
//  RESP: mem_op=00, gnt=0; pulse owner's valid/done, or timeout_err+err_id (no valid) if aborted; -> IDLE.
//  Latency: req seen in IDLE cycle N, op driven N+1, earliest response N+1, valid pulse N+2. Max throughput
//   one transaction per 3 cycles.
//  Requester may drop req mid-transaction: transaction still completes and pulses; req is only sampled in IDLE.
//  rd_valid/tx_done in IDLE or RESP ignored. rsp_data holds last read line until next read response.
//  err_id: 0=WR, 1=AU, 2=IF. Addresses latched in IDLE; later changes to *_addr have no effect.
// CONFIGURATION
//  MEM_ARB_RR_EN undefined: fixed priority WR > AU > IF.
//  MEM_ARB_RR_EN defined: round-robin; requester granted last has lowest priority next, order WR->AU->IF->WR;
//   pointer resets to "last = IF" (WR first) and advances only on grant (also on aborted grants).
// STRUCTURE
//  mem_arb_pkg: op_t enum (OP_IDLE=2'b00, OP_READ=2'b01, OP_WRITE=2'b10), req_id_t enum (ID_WR/ID_AU/ID_IF),
//   arb_state_t enum (IDLE/BUSY/RESP).
//  Sub-module mem_arb_pick: combinational 3-way picker (req vector, last-grant id) -> winner id + any_req;
//   contains the MEM_ARB_RR_EN select. FSM, timer, latches in top.
// TESTING
//  1 if_req, if_addr=0x100; rd_valid 3 cycles after op, bus=0xA5.. -> mem_op=01, mem_address=0x100 for 3 cycles,
//    if_gnt high throughout, if_valid 1 cycle later with rsp_data=0xA5..
//  2 wr/au/if req same cycle, all held, fixed priority -> grants WR (mem_op=10), then AU, then IF; 3 pulses.
//  3 TIMEOUT_CYC=16, au_req, no response -> 16 BUSY cycles, timeout_err=1 err_id=1, au_valid never asserted.
//  4 rst asserted in BUSY of IF read, rd_valid next cycle -> outputs 0 next cycle, no if_valid, state IDLE.
//  5 MEM_ARB_RR_EN, all three req held continuously -> grant order WR,AU,IF,WR,AU; fixed build -> WR repeatedly.
//  6 rd_valid/tx_done pulsed in IDLE, and tx_done during IF read -> no pulses, IF read completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: bus opcodes, requester ids, FSM states.
package mem_arb_pkg;

    localparam int unsigned NUM_REQ = 3;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10
    } op_t;

    typedef enum logic [1:0] {
        ID_WR = 2'd0,
        ID_AU = 2'd1,
        ID_IF = 2'd2
    } req_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Rotation order WR -> AU -> IF -> WR.
    function automatic req_id_t next_id(input req_id_t id);
        case (id)
            ID_WR:   next_id = ID_AU;
            ID_AU:   next_id = ID_IF;
            default: next_id = ID_WR;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 3-way requester picker.
// MEM_ARB_RR_EN defined: round-robin, requester after the last grant goes first.
// MEM_ARB_RR_EN undefined: fixed priority WR > AU > IF (last grant ignored).
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [1:0]         win,
    output logic               any_req
);

`ifdef MEM_ARB_RR_EN
    req_id_t c0, c1, c2;

    // Candidate order rotated so the most recent winner comes last.
    always_comb begin
        c0 = next_id(req_id_t'(last));
        c1 = next_id(c0);
        c2 = next_id(c1);
    end

    // First requesting candidate in rotated order wins.
    always_comb begin
        win     = ID_WR;
        any_req = |req;
        if (req[c0])      win = c0;
        else if (req[c1]) win = c1;
        else if (req[c2]) win = c2;
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    // Fixed priority, WR highest.
    always_comb begin
        win     = ID_WR;
        any_req = |req;
        if (req[ID_WR])      win = ID_WR;
        else if (req[ID_AU]) win = ID_AU;
        else if (req[ID_IF]) win = ID_IF;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port among host write (WR), audio read (AU)
// and instruction fetch (IF). One transaction at a time: IDLE -> BUSY -> RESP.
// Build option MEM_ARB_RR_EN selects round-robin instead of fixed priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDRW       = 32,
    parameter int unsigned INW         = 512,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic [ADDRW-1:0] wr_addr,
    output logic             wr_gnt,
    output logic             wr_done,
    input  logic             au_req,
    input  logic [ADDRW-1:0] au_addr,
    output logic             au_gnt,
    output logic             au_valid,
    input  logic             if_req,
    input  logic [ADDRW-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_valid,
    output logic [INW-1:0]   rsp_data,
    output logic [1:0]       mem_op,
    output logic [ADDRW-1:0] mem_address,
    input  logic             rd_valid,
    input  logic             tx_done,
    input  logic [INW-1:0]   common_data_bus_in,
    output logic             timeout_err,
    output logic [1:0]       err_id
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    arb_state_t         state, state_n;
    req_id_t            owner, owner_n;
    req_id_t            last_q, last_n;
    logic [TW-1:0]      timer, timer_n;
    logic [1:0]         op_n;
    logic [ADDRW-1:0]   maddr_n;
    logic [ADDRW-1:0]   sel_addr;
    logic [NUM_REQ-1:0] gnt_q, gnt_n;
    logic [NUM_REQ-1:0] pulse_q, pulse_n;
    logic [INW-1:0]     rsp_n;
    logic               tmo_n;
    logic [1:0]         err_n;
    logic [1:0]         win_raw;
    req_id_t            win;
    logic               any_req;
    logic               resp_hit;

    mem_arb_pick u_pick (
        .req     ({if_req, au_req, wr_req}),
        .last    (last_q),
        .win     (win_raw),
        .any_req (any_req)
    );

    assign win = req_id_t'(win_raw);

    assign wr_gnt   = gnt_q[ID_WR];
    assign au_gnt   = gnt_q[ID_AU];
    assign if_gnt   = gnt_q[ID_IF];
    assign wr_done  = pulse_q[ID_WR];
    assign au_valid = pulse_q[ID_AU];
    assign if_valid = pulse_q[ID_IF];

    // Address of the current winner, latched only when leaving IDLE.
    always_comb begin
        case (win)
            ID_AU:   sel_addr = au_addr;
            ID_IF:   sel_addr = if_addr;
            default: sel_addr = wr_addr;
        endcase
    end

    // Only the response type matching the owner's operation counts.
    always_comb begin
        resp_hit = (owner == ID_WR) ? tx_done : rd_valid;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last_q;
        timer_n = timer;
        op_n    = mem_op;
        maddr_n = mem_address;
        gnt_n   = gnt_q;
        pulse_n = '0;
        tmo_n   = 1'b0;
        err_n   = 2'b00;
        rsp_n   = rsp_data;
        case (state)
            IDLE: begin
                op_n    = OP_IDLE;
                maddr_n = '0;
                gnt_n   = '0;
                if (any_req) begin
                    state_n      = BUSY;
                    owner_n      = win;
                    last_n       = win;
                    timer_n      = '0;
                    op_n         = (win == ID_WR) ? OP_WRITE : OP_READ;
                    maddr_n      = sel_addr;
                    gnt_n[win]   = 1'b1;
                end
            end
            BUSY: begin
                if (resp_hit) begin
                    state_n        = RESP;
                    op_n           = OP_IDLE;
                    maddr_n        = '0;
                    gnt_n          = '0;
                    pulse_n[owner] = 1'b1;
                    if (owner != ID_WR) rsp_n = common_data_bus_in;
                end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                    state_n = RESP;
                    op_n    = OP_IDLE;
                    maddr_n = '0;
                    gnt_n   = '0;
                    tmo_n   = 1'b1;
                    err_n   = owner;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
                op_n    = OP_IDLE;
                maddr_n = '0;
                gnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                op_n    = OP_IDLE;
                maddr_n = '0;
                gnt_n   = '0;
            end
        endcase
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= ID_WR;
            last_q      <= ID_IF;
            timer       <= '0;
            mem_op      <= OP_IDLE;
            mem_address <= '0;
            gnt_q       <= '0;
            pulse_q     <= '0;
            timeout_err <= 1'b0;
            err_id      <= 2'b00;
            rsp_data    <= '0;
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            last_q      <= last_n;
            timer       <= timer_n;
            mem_op      <= op_n;
            mem_address <= maddr_n;
            gnt_q       <= gnt_n;
            pulse_q     <= pulse_n;
            timeout_err <= tmo_n;
            err_id      <= err_n;
            rsp_data    <= rsp_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle-level reference model plus directed scenarios.
module tb_mem_port_arbiter;

    localparam int unsigned ADDRW = 32;
    localparam int unsigned INW   = 512;
    localparam int unsigned TO    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_req = 1'b0, au_req = 1'b0, if_req = 1'b0;
    logic [ADDRW-1:0] wr_addr = '0, au_addr = '0, if_addr = '0;
    logic             wr_gnt, wr_done, au_gnt, au_valid, if_gnt, if_valid;
    logic [INW-1:0]   rsp_data;
    logic [1:0]       mem_op;
    logic [ADDRW-1:0] mem_address;
    logic             rd_valid = 1'b0, tx_done = 1'b0;
    logic [INW-1:0]   bus = '0;
    logic             timeout_err;
    logic [1:0]       err_id;

    mem_port_arbiter #(.ADDRW(ADDRW), .INW(INW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt), .wr_done(wr_done),
        .au_req(au_req), .au_addr(au_addr), .au_gnt(au_gnt), .au_valid(au_valid),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .rsp_data(rsp_data), .mem_op(mem_op), .mem_address(mem_address),
        .rd_valid(rd_valid), .tx_done(tx_done), .common_data_bus_in(bus),
        .timeout_err(timeout_err), .err_id(err_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [INW-1:0] act, input logic [INW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int               m_ph = 0;     // 0 waiting, 1 transaction open, 2 reporting
    int               m_owner = 0;
    int               m_age = 0;
    int               m_last = 2;
    bit               started = 1'b0;
    logic [1:0]       e_op = '0;
    logic [ADDRW-1:0] e_addr = '0;
    logic [2:0]       e_gnt = '0;
    logic [2:0]       e_pulse = '0;
    logic             e_tmo = 1'b0;
    logic [1:0]       e_err = '0;
    logic [INW-1:0]   e_rsp = '0;

    function automatic int model_pick(input logic [2:0] r, input int last);
        int idx;
`ifdef MEM_ARB_RR_EN
        for (int k = 1; k <= 3; k++) begin
            idx = (last + k) % 3;
            if (r[idx[1:0]]) return idx;
        end
`else
        for (int k = 0; k < 3; k++) begin
            idx = k;
            if (r[idx[1:0]]) return idx;
        end
`endif
        return -1;
    endfunction

    // Expected registered outputs after each rising edge.
    always @(posedge clk) begin
        int   w;
        logic resp;
        started = 1'b1;
        e_pulse = '0;
        e_tmo   = 1'b0;
        e_err   = '0;
        if (rst) begin
            m_ph = 0; m_last = 2;
            e_op = '0; e_addr = '0; e_gnt = '0; e_rsp = '0;
        end else if (m_ph == 0) begin
            w = model_pick({if_req, au_req, wr_req}, m_last);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_age = 0; m_ph = 1;
                e_op   = (w == 0) ? 2'b10 : 2'b01;
                e_addr = (w == 0) ? wr_addr : (w == 1) ? au_addr : if_addr;
                e_gnt  = 3'(1 << w);
            end
        end else if (m_ph == 1) begin
            resp = (m_owner == 0) ? tx_done : rd_valid;
            if (resp || m_age == TO - 1) begin
                m_ph = 2; e_op = '0; e_addr = '0; e_gnt = '0;
                if (resp) begin
                    e_pulse = 3'(1 << m_owner);
                    if (m_owner != 0) e_rsp = bus;
                end else begin
                    e_tmo = 1'b1;
                    e_err = 2'(m_owner);
                end
            end else begin
                m_age++;
            end
        end else begin
            m_ph = 0;
        end
    end

    // Observation counters and grant log.
    int n_wr = 0, n_au = 0, n_if = 0, n_tmo = 0;
    int gq[$];
    logic [1:0] prev_op = '0;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("cyc mem_op",      INW'(mem_op),      INW'(e_op));
            chk("cyc mem_address", INW'(mem_address), INW'(e_addr));
            chk("cyc gnt",         INW'({if_gnt, au_gnt, wr_gnt}), INW'(e_gnt));
            chk("cyc pulses",      INW'({if_valid, au_valid, wr_done}), INW'(e_pulse));
            chk("cyc timeout_err", INW'(timeout_err), INW'(e_tmo));
            chk("cyc err_id",      INW'(err_id),      INW'(e_err));
            chk("cyc rsp_data",    rsp_data,          e_rsp);
            if (wr_done)     n_wr++;
            if (au_valid)    n_au++;
            if (if_valid)    n_if++;
            if (timeout_err) n_tmo++;
            if (mem_op != 2'b00 && prev_op == 2'b00)
                gq.push_back(wr_gnt ? 0 : au_gnt ? 1 : if_gnt ? 2 : 3);
            prev_op = mem_op;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_op(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mem_op != 2'b00) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Answer the open transaction immediately with the matching response type.
    task automatic serve(input logic [INW-1:0] data, output int owner);
        bit ok;
        wait_op(ok);
        owner = -1;
        if (!ok) begin
            chk("serve wait_op timeout", INW'(0), INW'(1));
            return;
        end
        owner = wr_gnt ? 0 : au_gnt ? 1 : 2;
        if (owner == 0) tx_done = 1'b1;
        else begin rd_valid = 1'b1; bus = data; end
        tick(1);
        tx_done = 1'b0; rd_valid = 1'b0;
    endtask

    logic [INW-1:0] a5_line;
    int base_wr, base_au, base_if, base_tmo, cnt, owner;
    int exp5[5];

    initial begin
        a5_line = {64{8'hA5}};
        tick(2);
        rst = 1'b0;
        chk("reset mem_op",   INW'(mem_op),   INW'(0));
        chk("reset rsp_data", rsp_data,       INW'(0));
        chk("reset gnts",     INW'({if_gnt, au_gnt, wr_gnt}), INW'(0));
        tick(1);

        // 1: single fetch read, response on third op cycle
        if_req = 1'b1; if_addr = 32'h100;
        tick(1);
        chk("t1 op c1",   INW'(mem_op),      INW'(2'b01));
        chk("t1 addr c1", INW'(mem_address), INW'(32'h100));
        chk("t1 gnt c1",  INW'(if_gnt),      INW'(1));
        if_req = 1'b0; if_addr = 32'hDEAD_BEEF;
        tick(1);
        chk("t1 addr c2", INW'(mem_address), INW'(32'h100));
        tick(1);
        chk("t1 op c3",   INW'(mem_op),      INW'(2'b01));
        chk("t1 gnt c3",  INW'(if_gnt),      INW'(1));
        rd_valid = 1'b1; bus = a5_line;
        tick(1);
        rd_valid = 1'b0; bus = '0;
        chk("t1 if_valid", INW'(if_valid), INW'(1));
        chk("t1 rsp_data", rsp_data,       a5_line);
        chk("t1 op after", INW'(mem_op),   INW'(0));
        tick(1);
        chk("t1 if_valid drop", INW'(if_valid), INW'(0));
        chk("t1 rsp_data held", rsp_data,       a5_line);
        tick(1);

        // 2: three simultaneous requests, each dropped once served
        gq.delete();
        base_wr = n_wr; base_au = n_au; base_if = n_if;
        wr_req = 1'b1; au_req = 1'b1; if_req = 1'b1;
        wr_addr = 32'h2000; au_addr = 32'h3000; if_addr = 32'h4000;
        for (int i = 0; i < 3; i++) begin
            serve({16{32'hC0DE_0000 | 32'(i)}}, owner);
            if (owner == 0) wr_req = 1'b0;
            if (owner == 1) au_req = 1'b0;
            if (owner == 2) if_req = 1'b0;
        end
        tick(3);
        chk("t2 grant count", INW'(gq.size()), INW'(3));
        if (gq.size() == 3) begin
`ifdef MEM_ARB_RR_EN
            chk("t2 grant0", INW'(gq[0]), INW'(0));
            chk("t2 grant1", INW'(gq[1]), INW'(1));
            chk("t2 grant2", INW'(gq[2]), INW'(2));
`else
            chk("t2 grant0", INW'(gq[0]), INW'(0));
            chk("t2 grant1", INW'(gq[1]), INW'(1));
            chk("t2 grant2", INW'(gq[2]), INW'(2));
`endif
        end
        chk("t2 pulses", INW'({n_wr - base_wr, n_au - base_au, n_if - base_if}), INW'({32'd1, 32'd1, 32'd1}));

        // 3: audio read never answered -> abort after TO busy cycles
        base_au = n_au; base_tmo = n_tmo;
        au_req = 1'b1; au_addr = 32'h5000;
        tick(1);
        au_req = 1'b0;
        cnt = 0;
        while (mem_op != 2'b00 && cnt < 100) begin
            cnt++;
            tick(1);
        end
        chk("t3 busy cycles",  INW'(cnt),         INW'(TO));
        chk("t3 timeout_err",  INW'(timeout_err), INW'(1));
        chk("t3 err_id",       INW'(err_id),      INW'(1));
        chk("t3 au_valid",     INW'(au_valid),    INW'(0));
        tick(2);
        chk("t3 no au pulse",  INW'(n_au - base_au),   INW'(0));
        chk("t3 one abort",    INW'(n_tmo - base_tmo), INW'(1));

        // 4: reset during a fetch read, late rd_valid ignored
        base_if = n_if;
        if_req = 1'b1; if_addr = 32'h6000;
        tick(1);
        chk("t4 busy op", INW'(mem_op), INW'(2'b01));
        if_req = 1'b0; rst = 1'b1;
        tick(1);
        rst = 1'b0; rd_valid = 1'b1; bus = {16{32'hBAD0_BAD0}};
        chk("t4 op after rst",  INW'(mem_op),  INW'(0));
        chk("t4 gnt after rst", INW'(if_gnt),  INW'(0));
        chk("t4 rsp after rst", rsp_data,      INW'(0));
        tick(1);
        rd_valid = 1'b0; bus = '0;
        tick(2);
        chk("t4 no if pulse", INW'(n_if - base_if), INW'(0));
        chk("t4 idle op",     INW'(mem_op),         INW'(0));

        // 5: all requests held continuously for five transactions
        gq.delete();
`ifdef MEM_ARB_RR_EN
        exp5 = '{0, 1, 2, 0, 1};
`else
        exp5 = '{0, 0, 0, 0, 0};
`endif
        wr_req = 1'b1; au_req = 1'b1; if_req = 1'b1;
        for (int i = 0; i < 5; i++) serve({16{32'h0F0F_0000 | 32'(i)}}, owner);
        wr_req = 1'b0; au_req = 1'b0; if_req = 1'b0;
        tick(3);
        chk("t5 grant count", INW'(gq.size()), INW'(5));
        if (gq.size() == 5)
            for (int i = 0; i < 5; i++) chk($sformatf("t5 grant%0d", i), INW'(gq[i]), INW'(exp5[i]));

        // 6: stray responses in IDLE and wrong-type response during a read
        base_wr = n_wr; base_au = n_au; base_if = n_if;
        rd_valid = 1'b1; tx_done = 1'b1;
        tick(1);
        rd_valid = 1'b0; tx_done = 1'b0;
        tick(2);
        chk("t6 idle stray", INW'((n_wr - base_wr) + (n_au - base_au) + (n_if - base_if)), INW'(0));
        if_req = 1'b1; if_addr = 32'h7000;
        tick(1);
        if_req = 1'b0; tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("t6 still busy", INW'(mem_op),   INW'(2'b01));
        chk("t6 no if yet",  INW'(if_valid), INW'(0));
        rd_valid = 1'b1; bus = {16{32'h1234_5678}};
        tick(1);
        rd_valid = 1'b0; bus = '0;
        chk("t6 if_valid", INW'(if_valid), INW'(1));
        chk("t6 rsp_data", rsp_data,       {16{32'h1234_5678}});
        tick(3);
        chk("t6 if pulses", INW'(n_if - base_if), INW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
